// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: Decode operands/control to Execute, with stall, flush and bubble count.
// Latency: one clk cycle from D inputs to E outputs; no combinational input-to-output path.
// Backpressure: StallE holds the slot; FlushE (wins over StallE) loads an all-zero bubble.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic             ValidE,
    output logic [CNT_W-1:0] BubbleCount
);

    logic [XLEN-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, pc_d, pc_q, pc_plus4_d, pc_plus4_q, imm_d, imm_q;
    logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic             reg_write_d, reg_write_q, mem_write_d, mem_write_q;
    logic             jump_d, jump_q, branch_d, branch_q, alu_src_d, alu_src_q;
    logic [1:0]       result_src_d, result_src_q;
    logic [2:0]       alu_ctrl_d, alu_ctrl_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             bubble_inc;

    always_comb begin
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        alu_src_d    = alu_src_q;
        result_src_d = result_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        valid_d      = valid_q;
        bubble_inc   = 1'b0;

        if (FlushE) begin
            // Zeroed addresses keep the bubble out of forwarding/hazard matches.
            rd1_d        = '0;
            rd2_d        = '0;
            pc_d         = '0;
            pc_plus4_d   = '0;
            imm_d        = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            jump_d       = 1'b0;
            branch_d     = 1'b0;
            alu_src_d    = 1'b0;
            result_src_d = '0;
            alu_ctrl_d   = '0;
            valid_d      = 1'b0;
            bubble_inc   = 1'b1;
        end else if (!StallE) begin
            rd1_d        = RD1D;
            rd2_d        = RD2D;
            pc_d         = PCD;
            pc_plus4_d   = PCPlus4D;
            imm_d        = ImmExtD;
            rs1_d        = Rs1D;
            rs2_d        = Rs2D;
            rd_d         = RdD;
            reg_write_d  = RegWriteD;
            mem_write_d  = MemWriteD;
            jump_d       = JumpD;
            branch_d     = BranchD;
            alu_src_d    = ALUSrcD;
            result_src_d = ResultSrcD;
            alu_ctrl_d   = ALUControlD;
            valid_d      = ValidD;
            bubble_inc   = !ValidD;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            result_src_q <= '0;
            alu_ctrl_q   <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_src_q    <= alu_src_d;
            result_src_q <= result_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ImmExtE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ResultSrcE  = result_src_q;
    assign ALUControlE = alu_ctrl_q;
    assign ValidE      = valid_q;
    assign BubbleCount = bubble_cnt_q;

endmodule
